key_press_reader: RTL

//  Input-side partner of the LED blinker: reads one raw active-low push-button (KEY) on the 50 MHz board clock.

---
 rtl/key_press_reader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/key_press_reader.sv
// Push-button reader: sync, debounce, press/release/long strobes, toggle.
// Define AUTO_REPEAT_EN to re-fire PRESS_PULSE periodically while long-held.
module key_press_reader #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000,
  parameter int CNT_W           = 33
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic KEY,
  output logic PRESSED,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic LONG_PULSE,
  output logic TOGGLE
);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    LONG,
    DEB_REL
  } state_e;

  localparam logic [CNT_W-1:0] DEB_END =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_END =
    CNT_W'(LONG_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_END =
    CNT_W'(REPEAT_CYCLES - 1);
`endif

  if (DEBOUNCE_CYCLES < 2 ||
      LONG_CYCLES <= DEBOUNCE_CYCLES ||
      REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("key_press_reader: bad cycle parameters");
  end

  logic [1:0]       sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             long_q, long_d;
  logic             pressed_q, pressed_d;
  logic             toggle_q, toggle_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             lp_q, lp_d;
  logic             k_s;

  // Reset loads "released" so a key held through reset is re-debounced.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      long_q    <= 1'b0;
      pressed_q <= 1'b0;
      toggle_q  <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      lp_q      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], KEY};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      long_q    <= long_d;
      pressed_q <= pressed_d;
      toggle_q  <= toggle_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      lp_q      <= lp_d;
    end
  end

  assign k_s = ~sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    long_d    = long_q;
    pressed_d = pressed_q;
    toggle_d  = toggle_q;
    press_d   = 1'b0;
    rel_d     = 1'b0;
    lp_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (k_s) state_d = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!k_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_END) begin
          state_d   = HELD;
          press_d   = 1'b1;
          pressed_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!k_s) begin
          state_d = DEB_REL;
          cnt_d   = '0;
        end else if (cnt_q == LONG_END) begin
          state_d = LONG;
          lp_d    = 1'b1;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LONG: begin
        if (!k_s) begin
          state_d = DEB_REL;
          cnt_d   = '0;
        end
`ifdef AUTO_REPEAT_EN
        else if (cnt_q == REP_END) begin
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DEB_REL: begin
        if (k_s) begin
          state_d = long_q ? LONG : HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_END) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
          rel_d     = 1'b1;
          if (!long_q) toggle_d = ~toggle_q;
          long_d    = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign PRESSED       = pressed_q;
  assign PRESS_PULSE   = press_q;
  assign RELEASE_PULSE = rel_q;
  assign LONG_PULSE    = lp_q;
  assign TOGGLE        = toggle_q;

endmodule
